// File: rtl/uart_top.sv
// UART command accumulator: receives 8N1 bytes, runs ADD/CLR/MAC/RET on a 32-bit ACC.
// Ports: iClk, iRst (sync, active-high), iRx (serial in), oTx (serial out).
module uart_top #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iRx,
  output logic oTx
);

  localparam int CPB_RAW = CLK_FREQ / BAUD_RATE;
  localparam int CPB     = (CPB_RAW < 2) ? 2 : CPB_RAW;
  localparam int CW      = $clog2(CPB + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] LP_MID  = CW'((CPB - 1) / 2);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GET_OP = 3'd1;
  localparam logic [2:0] S_GET_A  = 3'd2;
  localparam logic [2:0] S_GET_B  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_SEND   = 3'd5;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_CLR = 8'h01;
  localparam logic [7:0] OP_MAC = 8'h02;
  localparam logic [7:0] OP_RET = 8'h03;

  // Receiver
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_valid;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_s1    <= iRx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_prev && !r_rx_s2) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == LP_MID) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            // A line already back high at mid-start is a glitch
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == LP_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          if (r_rx_cnt == LP_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            r_rx_valid <= r_rx_s2;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Transmitter
  logic          r_tx;
  logic          r_tx_busy;
  logic          r_tx_done;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;
  logic          r_tx_start;
  logic [7:0]    w_tx_byte;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (r_tx_start) begin
          r_tx_busy  <= 1'b1;
          r_tx       <= 1'b0;
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_tx_shift <= {1'b1, w_tx_byte};
        end
      end else if (r_tx_cnt == LP_LAST) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end else begin
          // Shift register ends in the stop bit, back-filled with idle ones
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bit   <= r_tx_bit + 1'b1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  assign oTx = r_tx;

  // Command FSM
  logic [2:0]  r_state;
  logic [7:0]  r_op;
  logic [31:0] r_acc, r_a, r_b;
  logic [1:0]  r_byte_cnt;
  logic [1:0]  w_last;
  logic [31:0] w_prod;

  assign w_last    = (r_op == OP_MAC) ? 2'd1 : 2'd3;
  assign w_prod    = {16'b0, r_a[15:0]} * {16'b0, r_b[15:0]};
  assign w_tx_byte = r_acc[{~r_byte_cnt, 3'b000} +: 8];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_acc      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_byte_cnt <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_rx_valid) begin
            r_op    <= r_rx_shift;
            r_state <= S_GET_OP;
          end
        end
        S_GET_OP: begin
          r_a        <= '0;
          r_b        <= '0;
          r_byte_cnt <= '0;
          case (r_op)
            OP_ADD, OP_MAC: r_state <= S_GET_A;
            OP_CLR:         r_state <= S_EXEC;
            OP_RET: begin
              r_tx_start <= 1'b1;
              r_state    <= S_SEND;
            end
            default:        r_state <= S_IDLE;
          endcase
        end
        S_GET_A: begin
          if (r_rx_valid) begin
            r_a        <= {r_a[23:0], r_rx_shift};
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == w_last) begin
              r_byte_cnt <= '0;
              r_state    <= S_GET_B;
            end
          end
        end
        S_GET_B: begin
          if (r_rx_valid) begin
            r_b        <= {r_b[23:0], r_rx_shift};
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == w_last) begin
              r_byte_cnt <= '0;
              r_state    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_ADD:  r_acc <= r_a + r_b;
            OP_MAC:  r_acc <= r_acc + w_prod;
            default: r_acc <= '0;
          endcase
          r_state <= S_IDLE;
        end
        default: begin
          if (r_tx_done) begin
            if (r_byte_cnt == 2'd3) begin
              r_byte_cnt <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_tx_start <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top at 10 clocks per bit.
// Replies on oTx are decoded and matched against a queue of expected bytes.
module tb_uart_top;

  localparam int CPB = 10;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic iRx  = 1'b1;
  logic oTx;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  logic [31:0] model_acc;

  uart_top #(.CLK_FREQ(100), .BAUD_RATE(10)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iRx (iRx),
    .oTx (oTx)
  );

  always #5 iClk = ~iClk;

  // Decode frames on oTx, sampling mid-bit on the falling clock edge
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge iClk);
      if (!iRst && oTx === 1'b0) begin
        repeat (4) @(negedge iClk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge iClk);
          d[i] = oTx;
        end
        repeat (CPB) @(negedge iClk);
        frames++;
        checks++;
        if (oTx !== 1'b1) begin
          errors++;
          $display("FAIL tx_stop: got %b want 1", oTx);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %h want no frame", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e) begin
            errors++;
            $display("FAIL tx_byte: got %h want %h", d, e);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(posedge iClk); #1;
    iRx = 1'b0;
    repeat (CPB) @(posedge iClk);
    #1;
    for (int i = 0; i < 8; i++) begin
      iRx = b[i];
      repeat (CPB) @(posedge iClk);
      #1;
    end
    iRx = stop_bit;
    repeat (CPB) @(posedge iClk);
    #1;
    iRx = 1'b1;
    repeat (2) @(posedge iClk);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1500) begin
      @(posedge iClk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes left want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (30) @(posedge iClk);
  endtask

  task automatic ret_expect(input logic [31:0] w, input string name);
    push_word(w);
    send_byte(8'h03);
    wait_drain(name);
  endtask

  task automatic send_mac(input logic [15:0] a, input logic [15:0] b);
    send_byte(8'h02);
    send_byte(a[15:8]); send_byte(a[7:0]);
    send_byte(b[15:8]); send_byte(b[7:0]);
  endtask

  task automatic send_add(input logic [31:0] a, input logic [31:0] b);
    send_byte(8'h00);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
  endtask

  task automatic pulse_reset();
    @(posedge iClk); #1;
    iRst = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if (oTx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b want 1", oTx);
    end
    @(posedge iClk); #1;
    iRst = 1'b0;
    repeat (5) @(posedge iClk);
  endtask

  task automatic test_reset();
    repeat (4) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if (oTx !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got %b want 1", oTx);
    end
    @(posedge iClk); #1;
    iRst = 1'b0;
    repeat (20) @(negedge iClk);
    checks++;
    if (oTx !== 1'b1) begin
      errors++;
      $display("FAIL idle_high: got %b want 1", oTx);
    end
  endtask

  task automatic test_ret_zero();
    ret_expect(32'h0000_0000, "ret_zero");
  endtask

  task automatic test_mac();
    for (int k = 0; k < 3; k++) send_mac(16'h2A4E, 16'h11C6);
    ret_expect(32'h08CF_B2FC, "mac");
  endtask

  task automatic test_add_wrap();
    send_add(32'hFFFF_FFFF, 32'h0000_0002);
    ret_expect(32'h0000_0001, "add_wrap");
  endtask

  task automatic test_clr_unknown();
    send_mac(16'h0005, 16'h0007);
    send_byte(8'h01);
    ret_expect(32'h0000_0000, "clr");
    send_byte(8'h7F);
    ret_expect(32'h0000_0000, "unknown_op");
    send_mac(16'h0005, 16'h0007);
    send_byte(8'h7F);
    ret_expect(32'h0000_0023, "unknown_keep");
  endtask

  task automatic test_glitch();
    int f0;
    @(posedge iClk); #1;
    iRx = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    iRx = 1'b1;
    repeat (150) @(posedge iClk);
    ret_expect(32'h0000_0023, "glitch");
    f0 = frames;
    send_byte(8'h01, 1'b0);
    repeat (150) @(posedge iClk);
    checks++;
    if (frames != f0) begin
      errors++;
      $display("FAIL bad_stop_frames: got %0d want %0d", frames, f0);
    end
    ret_expect(32'h0000_0023, "bad_stop");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h02);
    send_byte(8'h2A);
    pulse_reset();
    ret_expect(32'h0000_0000, "reset_mid");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [15:0] x, y;
    a = $urandom;
    b = $urandom;
    send_add(a, b);
    model_acc = a + b;
    for (int k = 0; k < 2; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      send_mac(x, y);
      model_acc = model_acc + {16'b0, x} * {16'b0, y};
    end
    ret_expect(model_acc, "random");
  endtask

  task automatic test_back_to_back();
    push_word(model_acc);
    send_byte(8'h03);
    send_byte(8'h03);
    wait_drain("b2b");
    repeat (600) @(posedge iClk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_queue: got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ret_zero();
    test_mac();
    test_add_wrap();
    test_clr_unknown();
    test_glitch();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
